mmio_uart_ctrl: RTL and testbench

- Memory-mapped I/O controller between the core's MEM stage and the on-chip `uart`.
- Decodes CPU loads and stores in the 0x8000_00xx window.
- Gives the UART transmitter a one-byte holding register and the UART receiver a small RX FIFO.
- Provides cycle and retired-instruction counters.
- Its `rdata` output joins the core's writeback load mux beside `dmem_dout` and `bios_douta`.

---
 rtl/mmio_uart_ctrl.sv | 146 ++++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART/counter controller: decodes the 0x8000_00xx window.
// It provides a one-byte TX holding register, an RX FIFO and cycle/instret counters.
module mmio_uart_ctrl #(
    parameter int unsigned RX_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  uart_data_in,
    output logic        uart_data_in_valid,
    input  logic        uart_data_in_ready,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_data_out_valid,
    output logic        uart_data_out_ready
);

    localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RX_DEPTH + 1);

    localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADDR_RXD    = 32'h8000_0004;
    localparam logic [31:0] ADDR_TXD    = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYC    = 32'h8000_0010;
    localparam logic [31:0] ADDR_INST   = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLR    = 32'h8000_0018;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_t;

    tx_state_t            tx_state;
    logic [7:0]           rx_mem [RX_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     rx_count;
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] inst_cnt;

    logic        store;
    logic        tx_wr;
    logic        cnt_clr;
    logic        rx_empty;
    logic        push;
    logic        pop;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign store    = (we != 4'd0);
    assign tx_wr    = store && (addr == ADDR_TXD);
    assign cnt_clr  = store && (addr == ADDR_CLR);
    assign rx_empty = (rx_count == CNT_W'(0));
    assign push     = uart_data_out_valid && uart_data_out_ready;
    assign pop      = re && (addr == ADDR_RXD) && !rx_empty;

    assign uart_data_out_ready = (rx_count != CNT_W'(RX_DEPTH));

    // Load data is taken from pre-edge state, before any same-cycle push/pop.
    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            ADDR_STATUS: rd_mux = {30'd0, !rx_empty, (tx_state == TX_EMPTY)};
            ADDR_RXD:    rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rd_ptr]};
            ADDR_CYC:    rd_mux = 32'(cyc_cnt);
            ADDR_INST:   rd_mux = 32'(inst_cnt);
            default:     rd_mux = 32'd0;
        endcase
    end

    // FIFO storage needs no reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rx_mem[wr_ptr] <= uart_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state           <= TX_EMPTY;
            uart_data_in       <= 8'd0;
            uart_data_in_valid <= 1'b0;
            rdata              <= 32'd0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            rx_count           <= '0;
            cyc_cnt            <= '0;
            inst_cnt           <= '0;
        end else begin
            if (re) begin
                rdata <= rd_mux;
            end

            // Stores that arrive while a byte is still held are dropped.
            case (tx_state)
                TX_EMPTY: begin
                    if (tx_wr) begin
                        uart_data_in       <= wdata[7:0];
                        uart_data_in_valid <= 1'b1;
                        tx_state           <= TX_FULL;
                    end
                end
                TX_FULL: begin
                    if (uart_data_in_ready) begin
                        uart_data_in_valid <= 1'b0;
                        tx_state           <= TX_EMPTY;
                    end
                end
                default: begin
                    uart_data_in_valid <= 1'b0;
                    tx_state           <= TX_EMPTY;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   rx_count <= rx_count + CNT_W'(1);
                2'b01:   rx_count <= rx_count - CNT_W'(1);
                default: rx_count <= rx_count;
            endcase

            if (cnt_clr) begin
                cyc_cnt  <= '0;
                inst_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
                if (inst_retire) begin
                    inst_cnt <= inst_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Bench for mmio_uart_ctrl: queue-based reference model checked every cycle,
// plus directed loads with literal expected values.
module tb_mmio_uart_ctrl;

    localparam int unsigned RX_DEPTH = 4;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXD    = 32'h8000_0004;
    localparam logic [31:0] A_TXD    = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INST   = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  uart_data_in;
    logic        uart_data_in_valid;
    logic        uart_data_in_ready;
    logic [7:0]  uart_data_out;
    logic        uart_data_out_valid;
    logic        uart_data_out_ready;

    mmio_uart_ctrl #(.RX_DEPTH(RX_DEPTH), .CNT_WIDTH(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .addr                (addr),
        .wdata               (wdata),
        .we                  (we),
        .re                  (re),
        .inst_retire         (inst_retire),
        .rdata               (rdata),
        .uart_data_in        (uart_data_in),
        .uart_data_in_valid  (uart_data_in_valid),
        .uart_data_in_ready  (uart_data_in_ready),
        .uart_data_out       (uart_data_out),
        .uart_data_out_valid (uart_data_out_valid),
        .uart_data_out_ready (uart_data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: TX flag + byte, RX byte queue, plain counters.
    logic [31:0] m_rdata;
    bit          m_tx_full;
    logic [7:0]  m_tx_byte;
    logic [7:0]  m_q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [31:0] m_rv;
    bit          m_push;

    always @(posedge clk) begin
        if (!rst) begin
            m_rdata = 0; m_tx_full = 0; m_tx_byte = 0;
            m_q.delete(); m_cyc = 0; m_inst = 0;
        end else begin
            m_rv = 0;
            if (addr == A_STATUS)                    m_rv = {30'd0, m_q.size() != 0, !m_tx_full};
            else if (addr == A_RXD && m_q.size() != 0) m_rv = {24'd0, m_q[0]};
            else if (addr == A_CYC)                  m_rv = m_cyc;
            else if (addr == A_INST)                 m_rv = m_inst;
            if (re) m_rdata = m_rv;

            m_push = uart_data_out_valid && (m_q.size() < RX_DEPTH);
            if (re && addr == A_RXD && m_q.size() != 0) void'(m_q.pop_front());
            if (m_push) m_q.push_back(uart_data_out);

            if (m_tx_full) begin
                if (uart_data_in_ready) m_tx_full = 0;
            end else if (we != 0 && addr == A_TXD) begin
                m_tx_full = 1;
                m_tx_byte = wdata[7:0];
            end

            if (we != 0 && addr == A_CLR) begin
                m_cyc = 0; m_inst = 0;
            end else begin
                m_cyc = m_cyc + 1;
                if (inst_retire) m_inst = m_inst + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", rdata, m_rdata);
            chk("tx_valid", 32'(uart_data_in_valid), 32'(m_tx_full));
            chk("tx_byte", 32'(uart_data_in), 32'(m_tx_byte));
            chk("rx_ready", 32'(uart_data_out_ready), 32'(m_q.size() < RX_DEPTH));
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        chk(nm, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 4'hf;
        @(negedge clk);
        we = 4'h0;
    endtask

    initial begin
        rst = 1'b0; addr = 0; wdata = 0; we = 0; re = 0; inst_retire = 0;
        uart_data_in_ready = 0; uart_data_out = 0; uart_data_out_valid = 0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", 32'(uart_data_in_valid), 32'h0);
        chk("rst_rx_ready", 32'(uart_data_out_ready), 32'h1);
        rd(A_STATUS, 32'h1, "rst_status");

        // TX holding register, transmitter stalled
        wr(A_TXD, 32'h0000_0041);
        chk("tx_valid_set", 32'(uart_data_in_valid), 32'h1);
        chk("tx_byte_41", 32'(uart_data_in), 32'h41);
        rd(A_STATUS, 32'h0, "status_tx_full");
        wr(A_TXD, 32'h0000_0042);
        chk("tx_drop_42", 32'(uart_data_in), 32'h41);
        uart_data_in_ready = 1'b1;
        @(negedge clk);
        chk("tx_valid_clr", 32'(uart_data_in_valid), 32'h0);
        chk("tx_byte_hold", 32'(uart_data_in), 32'h41);
        rd(A_STATUS, 32'h1, "status_tx_empty");

        // RX fill to full, fifth byte held off
        for (int i = 0; i < 4; i++) begin
            uart_data_out = 8'(8'h10 + i); uart_data_out_valid = 1'b1;
            @(negedge clk);
        end
        chk("rx_full_ready", 32'(uart_data_out_ready), 32'h0);
        uart_data_out = 8'h14;
        repeat (2) @(negedge clk);
        chk("rx_hold_ready", 32'(uart_data_out_ready), 32'h0);
        uart_data_out_valid = 1'b0;
        rd(A_STATUS, 32'h3, "status_rx_full");
        for (int i = 0; i < 4; i++) rd(A_RXD, 32'(32'h10 + i), "rx_pop_order");
        rd(A_STATUS, 32'h1, "status_rx_empty");
        rd(A_RXD, 32'h0, "rx_pop_empty");

        // Simultaneous push/pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            uart_data_out = 8'(8'h20 + i); uart_data_out_valid = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            uart_data_out = 8'(8'h22 + k); uart_data_out_valid = 1'b1;
            rd(A_RXD, 32'(32'h20 + k), "rx_pushpop");
            uart_data_out_valid = 1'b0;
        end
        rd(A_RXD, 32'h28, "rx_drain0");
        rd(A_RXD, 32'h29, "rx_drain1");
        rd(A_RXD, 32'h0, "rx_drain_empty");

        // Counters
        wr(A_CLR, 32'hdead_beef);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 74) && (i % 2 == 0);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        rd(A_INST, 32'd37, "inst_37");
        rd(A_CYC, 32'd101, "cyc_101");
        inst_retire = 1'b1;
        wr(A_CLR, 32'h0);
        inst_retire = 1'b0;
        rd(A_CYC, 32'd0, "cyc_clr");
        rd(A_INST, 32'd0, "inst_clr_prio");
        rd(A_CYC, 32'd2, "cyc_restart");

        // Address decode
        rd(32'h8000_000C, 32'h0, "unmapped_0c");
        rd(32'h9000_0000, 32'h0, "unmapped_9");
        wr(A_RXD, 32'h0000_00ab);
        rd(A_STATUS, 32'h1, "status_after_bad_wr");
        rd(A_RXD, 32'h0, "rxd_after_bad_wr");

        // Reset with a held TX byte and queued RX byte
        uart_data_in_ready = 1'b0;
        wr(A_TXD, 32'h55);
        uart_data_out = 8'h77; uart_data_out_valid = 1'b1;
        @(negedge clk);
        uart_data_out_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_tx_valid", 32'(uart_data_in_valid), 32'h0);
        chk("midrst_tx_byte", 32'(uart_data_in), 32'h0);
        chk("midrst_rx_ready", 32'(uart_data_out_ready), 32'h1);
        rd(A_STATUS, 32'h1, "midrst_status");
        rd(A_RXD, 32'h0, "midrst_rxd");

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
